// File: rtl/mem_access.sv
// Memory stage of the multi-cycle core: byte-addressed loads and stores against a
// local word-organised data memory, or pass-through of the execute result.
module mem_access #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enabled,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd_in,
  input  logic [31:0] alu_result,
  output logic        completed,
  output logic [4:0]  rd_out,
  output logic [31:0] rd_val,
  output logic        reg_we,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [2:0]            f3_q, f3_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic                  load_q, load_d;
  logic                  store_q, store_d;
  logic [31:0]           rd_val_q, rd_val_d;
  logic                  reg_we_q, reg_we_d;
  logic                  fault_q, fault_d;

  logic        start;
  logic        start_bad;
  logic        access;
  logic [3:0]  be;
  logic [31:0] wlanes;
  logic [31:0] rdata_q;
  logic [31:0] rshift;
  logic [31:0] load_val;
  logic        unused_addr;

  logic [31:0] mem_q [0:(1<<ADDR_WIDTH)-1];

  // Address bits above the memory size are deliberately dropped (wrap-around).
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

  assign start  = enabled && (state_q != WAIT);
  assign access = (state_q == WAIT) && (cnt_q == 3'd1);

  always_comb begin
    start_bad = 1'b0;
    if (is_load && is_store) begin
      start_bad = 1'b1;
    end else if (is_load) begin
      case (funct3)
        3'b000, 3'b100: start_bad = 1'b0;
        3'b001, 3'b101: start_bad = addr[0];
        3'b010:         start_bad = |addr[1:0];
        default:        start_bad = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000:  start_bad = 1'b0;
        3'b001:  start_bad = addr[0];
        3'b010:  start_bad = |addr[1:0];
        default: start_bad = 1'b1;
      endcase
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    f3_d     = f3_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    load_d   = load_q;
    store_d  = store_q;
    rd_val_d = rd_val_q;
    reg_we_d = reg_we_q;
    fault_d  = fault_q;

    if (state_q == WAIT) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d  = DONE;
        reg_we_d = load_q && (rd_q != 5'd0);
      end
    end else if (start) begin
      idx_d    = addr[ADDR_WIDTH+1:2];
      lane_d   = addr[1:0];
      f3_d     = funct3;
      wdata_d  = wdata;
      rd_d     = rd_in;
      load_d   = is_load;
      store_d  = is_store;
      rd_val_d = 32'd0;
      reg_we_d = 1'b0;
      fault_d  = 1'b0;
      if (start_bad) begin
        // A faulting access must never reach the memory or the load mux.
        state_d = DONE;
        fault_d = 1'b1;
        load_d  = 1'b0;
        store_d = 1'b0;
      end else if (!is_load && !is_store) begin
        state_d  = DONE;
        rd_val_d = alu_result;
        reg_we_d = (rd_in != 5'd0);
      end else begin
        state_d = WAIT;
        cnt_d   = 3'(LATENCY);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      lane_q   <= '0;
      f3_q     <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      rd_val_q <= '0;
      reg_we_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lane_q   <= lane_d;
      f3_q     <= f3_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      load_q   <= load_d;
      store_q  <= store_d;
      rd_val_q <= rd_val_d;
      reg_we_q <= reg_we_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00: begin
        be     = 4'b0001 << lane_q;
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be     = lane_q[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = wdata_q;
      end
    endcase
  end

  // NOTE: the data array and its read register are left out of reset so they
  // map onto plain RAM; contents survive a core reset.
  always_ff @(posedge clk) begin
    if (access) begin
      if (store_q) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_q[idx_q][8*b +: 8] <= wlanes[8*b +: 8];
        end
      end
      rdata_q <= mem_q[idx_q];
    end
  end

  assign rshift = rdata_q >> {lane_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'd0, rshift[7:0]};
      3'b101:  load_val = {16'd0, rshift[15:0]};
      default: load_val = rdata_q;
    endcase
  end

  assign completed = (state_q == DONE);
  assign rd_out    = rd_q;
  assign reg_we    = reg_we_q;
  assign fault     = fault_q;
  assign rd_val    = (completed && load_q) ? load_val : rd_val_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized traffic
// checked against a byte-array memory model.
module tb_mem_access;

  localparam int LAT = 3;
  localparam int ML  = LAT + 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] alu_result = '0;
  logic        completed;
  logic [4:0]  rd_out;
  logic [31:0] rd_val;
  logic        reg_we;
  logic        fault;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    int          lat;
    logic [31:0] val;
    logic        we;
    logic        flt;
    logic [4:0]  rd;
  } res_t;

  logic [7:0] mem_model [0:4095];

  mem_access #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rd_in(rd_in), .alu_result(alu_result), .completed(completed),
    .rd_out(rd_out), .rd_val(rd_val), .reg_we(reg_we), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic string fmt(input res_t r);
    return $sformatf("lat=%0d val=%h we=%b flt=%b rd=%0d", r.lat, r.val, r.we, r.flt, r.rd);
  endfunction

  function automatic res_t mk(input int lat, input logic [31:0] v, input logic we,
                              input logic flt, input logic [4:0] rd);
    res_t r;
    r.lat = lat; r.val = v; r.we = we; r.flt = flt; r.rd = rd;
    return r;
  endfunction

  // Reference: byte-addressed little-endian memory, wrapped at 4 KiB.
  function automatic res_t model_op(input logic ld, input logic st, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    input logic [31:0] alu, input logic [4:0] rd);
    res_t r;
    int size, base;
    logic bad;
    logic [31:0] v;
    r = mk(1, 32'd0, 1'b0, 1'b0, rd);
    if (!ld && !st) begin
      r.val = alu;
      r.we  = (rd != 5'd0);
      return r;
    end
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad = (ld && st)
       || (ld && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
       || (st && !(f3 inside {3'b000, 3'b001, 3'b010}))
       || ((int'(a[1:0]) % size) != 0);
    if (bad) begin
      r.flt = 1'b1;
      return r;
    end
    r.lat = ML;
    base = int'(a[11:0]);
    if (st) begin
      for (int i = 0; i < size; i++) mem_model[base + i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mem_model[base + i];
      if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      r.val = v;
      r.we  = (rd != 5'd0);
    end
    return r;
  endfunction

  // Pulse enabled for one cycle (two if hold is set, with junk inputs in the
  // second), then wait a bounded number of cycles for completed.
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] alu,
                       input logic [4:0] rd, input bit hold, output res_t got);
    int k;
    @(negedge clk);
    is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    alu_result = alu; rd_in = rd; enabled = 1'b1;
    @(posedge clk);
    #1;
    addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    alu_result = $urandom; rd_in = 5'($urandom);
    if (hold) begin
      is_load = 1'b0; is_store = 1'b0; rd_in = 5'd30;
    end else begin
      enabled = 1'b0; is_load = 1'($urandom); is_store = 1'($urandom);
    end
    k = 1;
    while (!completed && k < 20) begin
      @(posedge clk);
      #1;
      enabled = 1'b0;
      k++;
    end
    enabled = 1'b0;
    got = mk(completed ? k : -1, rd_val, reg_we, fault, rd_out);
  endtask

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] alu,
                        input logic [4:0] rd, input bit hold, output res_t got, output res_t mdl);
    do_op(ld, st, f3, a, wd, alu, rd, hold, got);
    mdl = model_op(ld, st, f3, a, wd, alu, rd);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    checks++;
    if ({completed, rd_out, rd_val, reg_we, fault} !== 40'd0) begin
      failures++;
      $display("FAIL reset_state: got c=%b rd=%0d val=%h we=%b flt=%b, expected all zero",
               completed, rd_out, rd_val, reg_we, fault);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_init();
    res_t got, mdl;
    for (int w = 0; w < 64; w++) begin
      run_op(1'b0, 1'b1, 3'b010, {20'($urandom), 4'h0, 8'(w * 4)}, $urandom, 32'd0,
             5'($urandom), 1'b0, got, mdl);
      checks++;
      if (got !== mdl) begin
        failures++;
        $display("FAIL init_sw[%0d]: got %s, expected %s", w, fmt(got), fmt(mdl));
      end
    end
  endtask

  task automatic test_store_load();
    res_t got, mdl;
    run_op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 5'd1, 1'b0, got, mdl);
    checks++;
    if (got !== mk(ML, 32'd0, 1'b0, 1'b0, 5'd1)) begin
      failures++; $display("FAIL sw_10: got %s, expected %s", fmt(got), fmt(mk(ML, 32'd0, 1'b0, 1'b0, 5'd1)));
    end
    run_op(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 5'd5, 1'b0, got, mdl);
    checks++;
    if (got !== mk(ML, 32'hDEADBEEF, 1'b1, 1'b0, 5'd5)) begin
      failures++; $display("FAIL lw_10: got %s, expected %s", fmt(got), fmt(mk(ML, 32'hDEADBEEF, 1'b1, 1'b0, 5'd5)));
    end
  endtask

  task automatic test_byte_lanes();
    res_t got, mdl;
    res_t exp [4];
    logic ld [4]   = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] f3 [4] = '{3'b000, 3'b010, 3'b000, 3'b100};
    logic [31:0] a [4] = '{32'h11, 32'h10, 32'h11, 32'h11};
    exp[0] = mk(ML, 32'd0, 1'b0, 1'b0, 5'd2);
    exp[1] = mk(ML, 32'hDEADAAEF, 1'b1, 1'b0, 5'd2);
    exp[2] = mk(ML, 32'hFFFFFFAA, 1'b1, 1'b0, 5'd2);
    exp[3] = mk(ML, 32'h000000AA, 1'b1, 1'b0, 5'd2);
    for (int i = 0; i < 4; i++) begin
      run_op(ld[i], !ld[i], f3[i], a[i], 32'h000000AA, 32'd0, 5'd2, 1'b0, got, mdl);
      checks++;
      if (got !== exp[i]) begin
        failures++; $display("FAIL byte_lane[%0d]: got %s, expected %s", i, fmt(got), fmt(exp[i]));
      end
    end
  endtask

  task automatic test_halfword();
    res_t got, mdl;
    res_t exp [5];
    logic ld [5]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] f3 [5] = '{3'b010, 3'b001, 3'b101, 3'b001, 3'b010};
    logic [31:0] a [5] = '{32'h10, 32'h12, 32'h12, 32'h10, 32'h10};
    logic [31:0] wd [5] = '{32'h80010000, 32'd0, 32'd0, 32'h1234BEEF, 32'd0};
    exp[0] = mk(ML, 32'd0, 1'b0, 1'b0, 5'd8);
    exp[1] = mk(ML, 32'hFFFF8001, 1'b1, 1'b0, 5'd8);
    exp[2] = mk(ML, 32'h00008001, 1'b1, 1'b0, 5'd8);
    exp[3] = mk(ML, 32'd0, 1'b0, 1'b0, 5'd8);
    exp[4] = mk(ML, 32'h8001BEEF, 1'b1, 1'b0, 5'd8);
    for (int i = 0; i < 5; i++) begin
      run_op(ld[i], !ld[i], f3[i], a[i], wd[i], 32'd0, 5'd8, 1'b0, got, mdl);
      checks++;
      if (got !== exp[i]) begin
        failures++; $display("FAIL halfword[%0d]: got %s, expected %s", i, fmt(got), fmt(exp[i]));
      end
    end
  endtask

  task automatic test_faults();
    res_t got, mdl;
    logic ld [6]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic st [6]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] f3 [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b010};
    logic [31:0] a [6] = '{32'h12, 32'h13, 32'h10, 32'h10, 32'h10, 32'h10};
    res_t exp;
    for (int i = 0; i < 6; i++) begin
      run_op(ld[i], st[i], f3[i], a[i], 32'h0000FFFF, 32'd0, 5'd9, 1'b0, got, mdl);
      exp = (i == 5) ? mk(ML, 32'h8001BEEF, 1'b1, 1'b0, 5'd9) : mk(1, 32'd0, 1'b0, 1'b1, 5'd9);
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL fault[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
  endtask

  task automatic test_non_mem();
    res_t got, mdl;
    run_op(1'b0, 1'b0, 3'b000, 32'h10, 32'd0, 32'h1234, 5'd7, 1'b0, got, mdl);
    checks++;
    if (got !== mk(1, 32'h1234, 1'b1, 1'b0, 5'd7)) begin
      failures++; $display("FAIL alu_rd7: got %s, expected %s", fmt(got), fmt(mk(1, 32'h1234, 1'b1, 1'b0, 5'd7)));
    end
    run_op(1'b0, 1'b0, 3'b000, 32'h10, 32'd0, 32'h1234, 5'd0, 1'b0, got, mdl);
    checks++;
    if (got !== mk(1, 32'h1234, 1'b0, 1'b0, 5'd0)) begin
      failures++; $display("FAIL alu_rd0: got %s, expected %s", fmt(got), fmt(mk(1, 32'h1234, 1'b0, 1'b0, 5'd0)));
    end
  endtask

  task automatic test_wrap();
    res_t got, mdl;
    run_op(1'b0, 1'b1, 3'b010, 32'h1000_0014, 32'hCAFE0001, 32'd0, 5'd1, 1'b0, got, mdl);
    run_op(1'b1, 1'b0, 3'b010, 32'h14, 32'd0, 32'd0, 5'd3, 1'b0, got, mdl);
    checks++;
    if (got !== mk(ML, 32'hCAFE0001, 1'b1, 1'b0, 5'd3)) begin
      failures++; $display("FAIL wrap_low: got %s, expected %s", fmt(got), fmt(mk(ML, 32'hCAFE0001, 1'b1, 1'b0, 5'd3)));
    end
    run_op(1'b0, 1'b1, 3'b010, 32'h0000_0FFC, 32'h600DF00D, 32'd0, 5'd1, 1'b0, got, mdl);
    run_op(1'b1, 1'b0, 3'b010, 32'h7FFF_FFFC, 32'd0, 32'd0, 5'd4, 1'b0, got, mdl);
    checks++;
    if (got !== mk(ML, 32'h600DF00D, 1'b1, 1'b0, 5'd4)) begin
      failures++; $display("FAIL wrap_top: got %s, expected %s", fmt(got), fmt(mk(ML, 32'h600DF00D, 1'b1, 1'b0, 5'd4)));
    end
  endtask

  task automatic test_ignore_in_wait();
    res_t got, mdl;
    run_op(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 32'd0, 5'd3, 1'b1, got, mdl);
    checks++;
    if (got !== mdl) begin
      failures++; $display("FAIL enabled_in_wait: got %s, expected %s", fmt(got), fmt(mdl));
    end
  endtask

  task automatic test_reset_mid_wait();
    res_t got, mdl;
    @(negedge clk);
    is_load = 1'b0; is_store = 1'b1; funct3 = 3'b010; addr = 32'h20;
    wdata = 32'h55; rd_in = 5'd9; enabled = 1'b1;
    @(posedge clk);
    #1;
    enabled = 1'b0;
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if ({completed, rd_out, rd_val, reg_we, fault} !== 40'd0) begin
      failures++;
      $display("FAIL async_reset_wait: got c=%b rd=%0d val=%h we=%b flt=%b, expected all zero",
               completed, rd_out, rd_val, reg_we, fault);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    run_op(1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 32'd0, 5'd4, 1'b0, got, mdl);
    checks++;
    if (got !== mdl) begin
      failures++; $display("FAIL abandoned_store: got %s, expected %s", fmt(got), fmt(mdl));
    end
  endtask

  task automatic test_random();
    res_t got, mdl;
    int kind;
    logic ld, st;
    logic [31:0] a;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 19);
      ld = (kind < 8) || (kind == 19);
      st = (kind >= 8 && kind < 16) || (kind == 19);
      a = $urandom;
      a[11:8] = 4'h0;
      run_op(ld, st, 3'($urandom), a, $urandom, $urandom, 5'($urandom), 1'b0, got, mdl);
      checks++;
      if (got !== mdl) begin
        failures++; $display("FAIL random[%0d]: got %s, expected %s", n, fmt(got), fmt(mdl));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = 8'd0;
    test_reset();
    test_init();
    test_store_load();
    test_byte_lanes();
    test_halfword();
    test_faults();
    test_non_mem();
    test_wrap();
    test_ignore_in_wait();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage between execute and register write-back in the multi-cycle core. It replaces the core's inline word-indexed `mem` array access.
- Takes the execute stage's result and performs the data-memory read or write for loads and stores, using byte addressing and byte enables.
- Returns the value and destination register that write-back commits.
- For non-memory instructions it passes the execute result through.
- Uses the same enabled/completed handshake as the decode and execute stages.

Parameters:
- ADDR_WIDTH, 10, log2 of data memory depth in 32-bit words (1024 words).
- LATENCY, 1, memory wait cycles for load/store (legal range 1..7).

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- enabled  in  1  one-cycle start pulse from the core FSM.
- is_load  in  1  instruction is LB/LH/LW/LBU/LHU.
- is_store  in  1  instruction is SB/SH/SW.
- funct3  in  3  access size/sign field of the instruction.
- addr  in  32  byte address (execute rd result).
- wdata  in  32  store data (rs2 value).
- rd_in  in  5  destination register number.
- alu_result  in  32  execute result, used for non-memory instructions.
- completed  out  1  result valid; held until the next accepted start or reset.
- rd_out  out  5  latched destination register.
- rd_val  out  32  value to write back.
- reg_we  out  1  write-back enable.
- fault  out  1  misaligned access or illegal funct3; no memory or register effect.

Behaviour:
- Reset (async, rstn=0): state=IDLE; completed=0, rd_out=0, rd_val=0, reg_we=0, fault=0. Memory contents are not reset.
  - Reset mid-WAIT abandons the access: no store is performed and no completed pulse is produced.
- States: IDLE, WAIT, DONE.
- Start acceptance:
  - A start is accepted only when enabled=1 in IDLE or DONE. enabled in WAIT is ignored.
  - On an accepted start, all inputs are latched and completed, reg_we and fault clear the next cycle.
- Transitions:
  - IDLE/DONE + enabled, non-memory instruction (is_load=is_store=0): go to DONE at T+1.
    - rd_val=alu_result.
    - reg_we=(rd_in!=0).
  - IDLE/DONE + enabled, fault: go to DONE at T+1 with fault=1, reg_we=0, and no memory write.
  - IDLE/DONE + enabled, valid load/store: go to WAIT with counter=LATENCY.
    - The counter decrements each cycle.
    - At counter==1 the access is performed and the state goes to DONE.
    - completed rises at T+LATENCY+1.
  - is_load and is_store both 1: treated as fault.
- Addressing:
  - word index = addr[ADDR_WIDTH+1:2].
  - Upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_WIDTH bytes.
  - byte lane = addr[1:0].
- Alignment and fault conditions:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Load funct3 not in {000,001,010,100,101} is a fault.
  - Store funct3 not in {000,001,010} is a fault.
- Loads (funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU):
  - The selected byte/halfword is taken from the addressed lane.
  - It is sign-extended (000/001) or zero-extended (100/101) to 32 bits.
  - reg_we=(rd_in!=0).
- Stores:
  - SB writes wdata[7:0] to the lane.
  - SH writes wdata[15:0] to lanes {addr[1],0}/+1.
  - SW writes the full word.
  - Unselected bytes are preserved.
  - reg_we=0; rd_val=0.
- Memory is a single-port synchronous array with byte write enables, one access per instruction.
- A load following a store to the same address in a later instruction returns the stored data.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 rd=5 -> rd_val=0xDEADBEEF, reg_we=1, rd_out=5; completed exactly LATENCY+1 cycles after each enabled pulse.
- SB addr=0x11 wdata=0x000000AA onto 0xDEADBEEF, then LW 0x10 -> 0xDEADAABEF merged to 0xDEADAAEF; then LB 0x11 -> 0xFFFFFFAA and LBU 0x11 -> 0x000000AA.
- LH addr=0x12 after SW 0x8001_0000 at 0x10 -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr=0x12 -> fault=1, reg_we=0; SH addr=0x13 -> fault=1 and a subsequent LW 0x10 shows memory unchanged.
- Non-memory: alu_result=0x1234 rd_in=7 -> completed at T+1, rd_val=0x1234, reg_we=1; same with rd_in=0 -> reg_we=0.
- Assert rstn=0 while in WAIT of SW 0x20 wdata=0x55 -> outputs return to 0 asynchronously; LW 0x20 afterwards returns the pre-store value.
